float_arg_packer: RTL and testbench
===================================

Name: float_arg_packer

Overview:
- Upstream feeder for the floating-point discriminant pipeline.
- Accepts a serial stream of FLEN-bit coefficients on a valid/ready handshake.
- Groups each three consecutive words as a, b, c and issues them as one parallel triple with a single-cycle arg_vld pulse.
- Holds the triple while the downstream busy is high. Supports frame resynchronisation and keeps a saturating count of issued triples.

Parameters:
- FLEN, 8, width of one floating-point word (matches the downstream FLEN).
- EXP_W, 4, exponent field width; the field is bits [FLEN-2 -: EXP_W]. Used only by the optional feature.
- CNT_W, 16, width of the issued-triple counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_vld  in  1  input word valid
- in_first  in  1  marks the current input word as coefficient a (start of frame)
- in_data  in  FLEN  input coefficient word
- in_rdy  out  1  packer can accept a word this cycle
- ds_busy  in  1  downstream busy; no issue while high
- arg_vld  out  1  one-cycle pulse; a/b/c valid
- a  out  FLEN  coefficient a
- b  out  FLEN  coefficient b
- c  out  FLEN  coefficient c
- arg_special  out  1  at least one of a/b/c is NaN/Inf (optional feature)
- frame_err  out  1  one-cycle pulse; a partial triple was discarded
- issued_cnt  out  CNT_W  number of triples issued, saturating

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high. All state is held in flops on posedge clk or posedge rst.
- Reset values:
  - state = WAIT_A
  - arg_vld = 0, frame_err = 0, arg_special = 0
  - a = b = c = 0
  - issued_cnt = 0
  - collection registers = 0
- A word is accepted on a clock edge where in_vld && in_rdy.
- in_rdy is combinational: in_rdy = (state != ISSUE).
- States and transitions:
  - WAIT_A: on accept, store the word in the a-collection register and go to WAIT_B. in_first is ignored here.
  - WAIT_B: on accept with in_first=0, store b and go to WAIT_C. On accept with in_first=1, store the word as the new a, stay in WAIT_B, and pulse frame_err the next cycle.
  - WAIT_C: on accept with in_first=0, store c and go to ISSUE. On accept with in_first=1, store the word as the new a, go to WAIT_B, and pulse frame_err.
  - ISSUE: no accept. On an edge with ds_busy=0, load outputs a/b/c from the collection registers, set arg_vld=1 for exactly the next cycle, increment issued_cnt, and go to WAIT_A. With ds_busy=1, stay in ISSUE.
- Outputs a/b/c are stable from the arg_vld cycle until the next issue. They are never changed by the collection of later words.
- Latency:
  - c accepted at edge N, state ISSUE during cycle N..N+1.
  - With ds_busy=0, issue at edge N+1 and arg_vld high in cycle N+1..N+2.
  - Minimum 4 cycles per triple.
- A word accepted in WAIT_A during the arg_vld cycle is legal and starts the next triple.
- issued_cnt saturates at all-ones and never wraps.
- frame_err is a registered pulse, high for exactly one cycle per discard.
- Reset mid-frame or mid-ISSUE discards the partial or pending triple with no arg_vld, and returns to the reset values.
- in_vld=0 in any WAIT state leaves the state unchanged.
- No data-dependent stalls.

Optional Feature:
- Macro: FLOAT_ARG_PACKER_CLASSIFY_EN.
- Defined:
  - Each word is classified as special when its exponent field is all ones; this covers NaN and Inf.
  - A sticky per-frame flag ORs the classification of the a, b and c words. It is cleared on WAIT_A accept and on resync.
  - arg_special is registered alongside arg_vld, with the same cycle and the same hold behaviour as a/b/c.
- Not defined: arg_special is tied to 0 and no classification logic is built.

Test Plan:
- Basic triple: words 0x38, 0x40, 0x30 with in_first on the first, ds_busy=0 -> a=0x38, b=0x40, c=0x30; one arg_vld pulse 1 cycle after the c accept; issued_cnt=1.
- Backpressure: ds_busy=1 for 5 cycles after c -> in_rdy=0 and no arg_vld while busy; arg_vld appears the cycle after ds_busy falls; in_vld held high with word 0x11 is not accepted until WAIT_A.
- Resync: words 0x10, 0x20, then 0x30 with in_first=1, then 0x40, 0x50 -> frame_err pulses once; issued triple is a=0x30, b=0x40, c=0x50.
- Back-to-back: 4 triples streamed with in_vld always 1 -> arg_vld every 4th cycle; each issued a/b/c correct; issued_cnt=4.
- Reset mid-frame: assert rst after accepting a and b -> no arg_vld; all outputs 0; next 3 words form a fresh triple.
- Classify (macro defined): b=0x78 (exponent all ones), a=0x38, c=0x30 -> arg_special=1 with arg_vld; next clean triple -> arg_special=0. Macro undefined -> arg_special=0 always.

Source files
------------

// File: rtl/float_arg_packer.sv
// Packs serial FLEN-bit words into a/b/c triples; FLOAT_ARG_PACKER_CLASSIFY_EN adds NaN/Inf flagging.
// Issue one cycle after the c accept (4 cycles/triple min); ds_busy holds the triple and drops in_rdy.
module float_arg_packer #(
  parameter int FLEN  = 8,
  parameter int EXP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_first,
  input  logic [FLEN-1:0]  in_data,
  output logic             in_rdy,
  input  logic             ds_busy,
  output logic             arg_vld,
  output logic [FLEN-1:0]  a,
  output logic [FLEN-1:0]  b,
  output logic [FLEN-1:0]  c,
  output logic             arg_special,
  output logic             frame_err,
  output logic [CNT_W-1:0] issued_cnt
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_C, ISSUE} state_t;

  state_t          state;
  logic [FLEN-1:0] col_a, col_b, col_c;

  assign in_rdy = (state != ISSUE);

  if (EXP_W < 1 || EXP_W > FLEN - 1) begin : g_bad_exp_w
    $error("EXP_W must fit below the sign bit of a FLEN-bit word");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_A;
      col_a      <= '0;
      col_b      <= '0;
      col_c      <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      arg_vld    <= 1'b0;
      frame_err  <= 1'b0;
      issued_cnt <= '0;
    end else begin
      arg_vld   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_A: begin
          if (in_vld) begin
            col_a <= in_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (in_vld) begin
            // A new frame start here abandons the partial triple and restarts it.
            if (in_first) begin
              col_a     <= in_data;
              frame_err <= 1'b1;
            end else begin
              col_b <= in_data;
              state <= WAIT_C;
            end
          end
        end
        WAIT_C: begin
          if (in_vld) begin
            if (in_first) begin
              col_a     <= in_data;
              frame_err <= 1'b1;
              state     <= WAIT_B;
            end else begin
              col_c <= in_data;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!ds_busy) begin
            a       <= col_a;
            b       <= col_b;
            c       <= col_c;
            arg_vld <= 1'b1;
            if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
            state   <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

`ifdef FLOAT_ARG_PACKER_CLASSIFY_EN
  logic word_special;
  logic frame_special;

  // All-ones exponent covers both Inf and NaN.
  assign word_special = &in_data[FLEN-2 -: EXP_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_special <= 1'b0;
      arg_special   <= 1'b0;
    end else begin
      case (state)
        WAIT_A: begin
          if (in_vld) frame_special <= word_special;
        end
        WAIT_B, WAIT_C: begin
          if (in_vld) frame_special <= in_first ? word_special : (frame_special | word_special);
        end
        ISSUE: begin
          if (!ds_busy) arg_special <= frame_special;
        end
        default: ;
      endcase
    end
  end
`else
  assign arg_special = 1'b0;
`endif

endmodule

// File: tb/tb_float_arg_packer.sv
// Directed bench for float_arg_packer; the counter is narrowed so saturation is reachable.
module tb_float_arg_packer;
  localparam int FLEN  = 8;
  localparam int CNT_W = 4;
`ifdef FLOAT_ARG_PACKER_CLASSIFY_EN
  localparam bit SPECIAL_EXP = 1'b1;
`else
  localparam bit SPECIAL_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld, in_first, in_rdy, ds_busy;
  logic [FLEN-1:0]  in_data, a, b, c;
  logic             arg_vld, arg_special, frame_err;
  logic [CNT_W-1:0] issued_cnt;

  int errors = 0;
  int checks = 0;
  int vld_pulses = 0;

  float_arg_packer #(.FLEN(FLEN), .EXP_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_first(in_first), .in_data(in_data),
    .in_rdy(in_rdy), .ds_busy(ds_busy), .arg_vld(arg_vld), .a(a), .b(b), .c(c),
    .arg_special(arg_special), .frame_err(frame_err), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (arg_vld === 1'b1) vld_pulses++;

  // Present one word for the next rising edge, then land on the following falling edge.
  task automatic drive(input logic [7:0] d, input logic f);
    in_vld = 1'b1; in_data = d; in_first = f;
    @(negedge clk);
  endtask

  task automatic idle();
    in_vld = 1'b0; in_first = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a !== 8'h00 || b !== 8'h00 || c !== 8'h00) begin errors++; $display("FAIL reset_abc got %h %h %h want 00 00 00", a, b, c); end
    checks++; if (arg_vld !== 1'b0 || frame_err !== 1'b0 || arg_special !== 1'b0) begin errors++; $display("FAIL reset_flags got vld=%b ferr=%b spec=%b want 0 0 0", arg_vld, frame_err, arg_special); end
    checks++; if (issued_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", issued_cnt); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", in_rdy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drive(8'h38, 1'b1);
    drive(8'h40, 1'b0);
    drive(8'h30, 1'b0);
    checks++; if (in_rdy !== 1'b0 || arg_vld !== 1'b0) begin errors++; $display("FAIL basic_issue_state got rdy=%b vld=%b want 0 0", in_rdy, arg_vld); end
    idle();
    checks++; if (arg_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got %b want 1", arg_vld); end
    checks++; if (a !== 8'h38 || b !== 8'h40 || c !== 8'h30) begin errors++; $display("FAIL basic_abc got %h %h %h want 38 40 30", a, b, c); end
    checks++; if (issued_cnt !== 4'd1) begin errors++; $display("FAIL basic_cnt got %0d want 1", issued_cnt); end
    idle();
    checks++; if (arg_vld !== 1'b0 || a !== 8'h38) begin errors++; $display("FAIL basic_pulse_hold got vld=%b a=%h want 0 38", arg_vld, a); end
  endtask

  task automatic test_backpressure();
    ds_busy = 1'b1;
    drive(8'h01, 1'b1);
    drive(8'h02, 1'b0);
    drive(8'h03, 1'b0);
    in_vld = 1'b1; in_data = 8'h11; in_first = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_rdy !== 1'b0 || arg_vld !== 1'b0 || a !== 8'h38) begin errors++; $display("FAIL bp_hold[%0d] got rdy=%b vld=%b a=%h want 0 0 38", i, in_rdy, arg_vld, a); end
      @(negedge clk);
    end
    ds_busy = 1'b0;
    @(negedge clk);
    checks++; if (arg_vld !== 1'b1 || a !== 8'h01 || b !== 8'h02 || c !== 8'h03) begin errors++; $display("FAIL bp_issue got vld=%b %h %h %h want 1 01 02 03", arg_vld, a, b, c); end
    checks++; if (issued_cnt !== 4'd2 || in_rdy !== 1'b1) begin errors++; $display("FAIL bp_cnt_rdy got cnt=%0d rdy=%b want 2 1", issued_cnt, in_rdy); end
    @(negedge clk);
    drive(8'h12, 1'b0);
    drive(8'h13, 1'b0);
    idle();
    checks++; if (arg_vld !== 1'b1 || a !== 8'h11 || b !== 8'h12 || c !== 8'h13) begin errors++; $display("FAIL bp_next got vld=%b %h %h %h want 1 11 12 13", arg_vld, a, b, c); end
    checks++; if (issued_cnt !== 4'd3) begin errors++; $display("FAIL bp_next_cnt got %0d want 3", issued_cnt); end
  endtask

  task automatic test_resync();
    drive(8'h10, 1'b1);
    drive(8'h20, 1'b0);
    drive(8'h30, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL resync_c_err got %b want 1", frame_err); end
    drive(8'h40, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL resync_err_pulse got %b want 0", frame_err); end
    drive(8'h50, 1'b0);
    idle();
    checks++; if (arg_vld !== 1'b1 || a !== 8'h30 || b !== 8'h40 || c !== 8'h50) begin errors++; $display("FAIL resync_c_abc got vld=%b %h %h %h want 1 30 40 50", arg_vld, a, b, c); end
    drive(8'h60, 1'b1);
    drive(8'h61, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL resync_b_err got %b want 1", frame_err); end
    drive(8'h62, 1'b0);
    drive(8'h63, 1'b0);
    idle();
    checks++; if (arg_vld !== 1'b1 || a !== 8'h61 || b !== 8'h62 || c !== 8'h63) begin errors++; $display("FAIL resync_b_abc got vld=%b %h %h %h want 1 61 62 63", arg_vld, a, b, c); end
    checks++; if (issued_cnt !== 4'd5) begin errors++; $display("FAIL resync_cnt got %0d want 5", issued_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [12];
    int wi, t, last;
    bit acc;
    for (int i = 0; i < 12; i++) w[i] = 8'hA0 + 8'(i);
    wi = 0; t = 0; last = 0;
    for (int cyc = 0; cyc < 60 && t < 4; cyc++) begin
      if (wi < 12) begin
        in_vld = 1'b1; in_data = w[wi]; in_first = (wi % 3 == 0);
      end else begin
        in_vld = 1'b0; in_first = 1'b0;
      end
      acc = in_vld && in_rdy;
      @(negedge clk);
      if (acc) wi++;
      if (arg_vld === 1'b1) begin
        checks++; if (a !== w[3*t] || b !== w[3*t+1] || c !== w[3*t+2]) begin errors++; $display("FAIL b2b_abc[%0d] got %h %h %h want %h %h %h", t, a, b, c, w[3*t], w[3*t+1], w[3*t+2]); end
        if (t > 0) begin
          checks++; if (cyc - last != 4) begin errors++; $display("FAIL b2b_period[%0d] got %0d want 4", t, cyc - last); end
        end
        last = cyc;
        t++;
      end
    end
    in_vld = 1'b0;
    checks++; if (t != 4) begin errors++; $display("FAIL b2b_timeout got %0d triples want 4", t); end
    checks++; if (issued_cnt !== 4'd9) begin errors++; $display("FAIL b2b_cnt got %0d want 9", issued_cnt); end
    @(negedge clk);
  endtask

  task automatic test_classify();
    drive(8'h38, 1'b1);
    drive(8'h78, 1'b0);
    drive(8'h30, 1'b0);
    idle();
    checks++; if (arg_vld !== 1'b1 || arg_special !== SPECIAL_EXP) begin errors++; $display("FAIL classify_special got vld=%b spec=%b want 1 %b", arg_vld, arg_special, SPECIAL_EXP); end
    idle();
    checks++; if (arg_special !== SPECIAL_EXP) begin errors++; $display("FAIL classify_hold got %b want %b", arg_special, SPECIAL_EXP); end
    drive(8'h38, 1'b1);
    drive(8'h40, 1'b0);
    drive(8'h30, 1'b0);
    idle();
    checks++; if (arg_vld !== 1'b1 || arg_special !== 1'b0) begin errors++; $display("FAIL classify_clean got vld=%b spec=%b want 1 0", arg_vld, arg_special); end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    for (int k = 1; k <= 6; k++) begin
      drive(8'h01, 1'b1);
      drive(8'h02, 1'b0);
      drive(8'h03, 1'b0);
      idle();
      exp_cnt = (11 + k > 15) ? 15 : 11 + k;
      checks++; if (arg_vld !== 1'b1 || issued_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got vld=%b cnt=%0d want 1 %0d", k, arg_vld, issued_cnt, exp_cnt); end
    end
  endtask

  task automatic test_reset_midframe();
    int p;
    drive(8'h21, 1'b1);
    drive(8'h22, 1'b0);
    in_vld = 1'b0;
    p = vld_pulses;
    rst = 1'b1;
    #1;
    checks++; if (a !== 8'h00 || b !== 8'h00 || c !== 8'h00 || issued_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_clear got %h %h %h cnt=%0d want 00 00 00 0", a, b, c, issued_cnt); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (vld_pulses != p || arg_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_novld got %0d pulses want 0", vld_pulses - p); end
    drive(8'h31, 1'b0);
    drive(8'h32, 1'b0);
    drive(8'h33, 1'b0);
    idle();
    checks++; if (arg_vld !== 1'b1 || a !== 8'h31 || b !== 8'h32 || c !== 8'h33) begin errors++; $display("FAIL rst_mid_fresh got vld=%b %h %h %h want 1 31 32 33", arg_vld, a, b, c); end
    checks++; if (issued_cnt !== 4'd1) begin errors++; $display("FAIL rst_mid_cnt got %0d want 1", issued_cnt); end
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_first = 1'b0; in_data = '0; ds_busy = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_resync();
    test_back_to_back();
    test_classify();
    test_saturate();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
